// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU definitions: FSM state encoding, counter width and datapath sizes.
// Used by the hazard controller, its counter sub-module and its interface.
package cpu_pkg;

  localparam int WORD_SIZE = 16;
  localparam int REG_SIZE  = 16;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_IWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave).
// Carries the hazard indicators in one direction and the latch controls in the other.
interface pipeline_hazard_ctrl_if
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 2
) ();

  // No valid/ready pair here: every hazard input is a level sampled in the current
  // cycle, and imem_ready/dmem_ready are ready-style strobes meaning "the access
  // completes this cycle"; the enables answer combinationally in the same cycle.
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic                  id_jump;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_branch_taken;
  logic                  imem_ready;
  logic                  mem_access;
  logic                  dmem_ready;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_write;
  logic                  ex_mem_write;
  logic                  mem_wb_write;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, ex_mem_read, ex_rd,
           ex_branch_taken, imem_ready, mem_access, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, ex_mem_read, ex_rd,
           ex_branch_taken, imem_ready, mem_access, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush, mem_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter16.sv
// 16-bit up counter with synchronous clear that sticks at all-ones.
// Clear takes precedence over increment.
module sat_counter16
  import cpu_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_N,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: latch enables, bubbles,
// memory-wait FSM, wait watchdog and stall/flush performance counters.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  pipeline_hazard_ctrl_if.slave hz,
  output state_t                o_dbg_state
);

  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_live;
  logic                  r_timeout;
  logic [REG_ADDR_W-1:0] w_id_rs;
  logic [REG_ADDR_W-1:0] w_id_rt;
  logic [REG_ADDR_W-1:0] w_ex_rd;
  logic                  w_data_wait;
  logic                  w_load_use;
  logic                  w_fetch_wait;
  logic                  w_pc_we;
  logic                  w_ifid_we;
  logic                  w_idex_we;
  logic                  w_exmem_we;
  logic                  w_memwb_we;
  logic                  w_ifid_fl;
  logic                  w_idex_fl;
  logic                  w_flush_ev;
  logic                  w_in_wait;
  logic                  w_wait_inc;
  logic                  w_wait_clr;
  logic                  w_stall_inc;
  logic                  w_flush_inc;
  logic [CNT_W-1:0]      w_wait_cnt;
  logic [CNT_W-1:0]      w_stall_cnt;
  logic [CNT_W-1:0]      w_flush_cnt;

  assign w_id_rs      = hz.id_rs;
  assign w_id_rt      = hz.id_rt;
  assign w_ex_rd      = hz.ex_rd;
  assign w_data_wait  = hz.mem_access & ~hz.dmem_ready;
  assign w_fetch_wait = ~hz.imem_ready;
  assign w_load_use   = hz.ex_mem_read &
                        ((hz.id_use_rs & (w_id_rs == w_ex_rd)) |
                         (hz.id_use_rt & (w_id_rt == w_ex_rd)));

  // Same priority table in every state; the state only tracks which wait is open.
  always_comb begin
    w_pc_we     = 1'b1;
    w_ifid_we   = 1'b1;
    w_idex_we   = 1'b1;
    w_exmem_we  = 1'b1;
    w_memwb_we  = 1'b1;
    w_ifid_fl   = 1'b0;
    w_idex_fl   = 1'b0;
    w_flush_ev  = 1'b0;
    w_state_nxt = ST_RUN;
    if (w_data_wait) begin
      w_pc_we     = 1'b0;
      w_ifid_we   = 1'b0;
      w_idex_we   = 1'b0;
      w_exmem_we  = 1'b0;
      w_memwb_we  = 1'b0;
      w_state_nxt = ST_DWAIT;
    end else if (hz.ex_branch_taken) begin
      w_ifid_fl  = 1'b1;
      w_idex_fl  = 1'b1;
      w_flush_ev = 1'b1;
    end else if (w_load_use) begin
      w_pc_we   = 1'b0;
      w_ifid_we = 1'b0;
      w_idex_fl = 1'b1;
    end else if (hz.id_jump) begin
      w_ifid_fl  = 1'b1;
      w_flush_ev = 1'b1;
    end else if (w_fetch_wait) begin
      w_pc_we     = 1'b0;
      w_ifid_fl   = 1'b1;
      w_state_nxt = ST_IWAIT;
    end
  end

  // r_live drops asynchronously with reset and returns on the first clock edge after it.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state <= ST_RUN;
    end else if (r_live) begin
      r_state <= w_state_nxt;
    end
  end

  assign w_in_wait  = (r_state != ST_RUN);
  assign w_wait_clr = r_live & (w_state_nxt == ST_RUN);
  assign w_wait_inc = w_in_wait & ~w_wait_clr;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_timeout <= 1'b0;
    end else if (w_wait_inc && (w_wait_cnt == TIMEOUT_M1)) begin
      r_timeout <= 1'b1;
    end
  end

  assign w_stall_inc = r_live & ~w_pc_we;
  assign w_flush_inc = r_live & w_flush_ev;

  sat_counter16 u_wait_cnt (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .i_inc   (w_wait_inc),
    .i_clr   (w_wait_clr),
    .o_count (w_wait_cnt)
  );

  sat_counter16 u_stall_cnt (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .i_inc   (w_stall_inc),
    .i_clr   (1'b0),
    .o_count (w_stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .i_inc   (w_flush_inc),
    .i_clr   (1'b0),
    .o_count (w_flush_cnt)
  );

  assign hz.pc_write     = r_live & w_pc_we;
  assign hz.if_id_write  = r_live & w_ifid_we;
  assign hz.id_ex_write  = r_live & w_idex_we;
  assign hz.ex_mem_write = r_live & w_exmem_we;
  assign hz.mem_wb_write = r_live & w_memwb_we;
  assign hz.if_id_flush  = r_live & w_ifid_fl;
  assign hz.id_ex_flush  = r_live & w_idex_fl;
  assign hz.mem_timeout  = r_timeout;
  assign hz.stall_cnt    = w_stall_cnt;
  assign hz.flush_cnt    = w_flush_cnt;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, hand-written wait/reset/saturation
// sequences and random traffic against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
  import cpu_pkg::*;

  localparam int TO = 4;

  typedef struct packed {
    logic [1:0] id_rs;
    logic [1:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_jump;
    logic       ex_mem_read;
    logic [1:0] ex_rd;
    logic       ex_branch_taken;
    logic       imem_ready;
    logic       mem_access;
    logic       dmem_ready;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [6:0] exp;
  } vec_t;

  // Control word order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  localparam logic [6:0] RULE_OUT [6] = '{
    7'b0000000,  // data wait
    7'b1111111,  // branch
    7'b0011101,  // load-use
    7'b1111110,  // jump
    7'b0111110,  // fetch wait
    7'b1111100   // normal
  };

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_checks;
  int     n_errors;

  logic [6:0] exp_q[$];

  int m_stall, m_flush, m_wait, m_kind;
  bit m_timeout, m_live;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(2)) hz_if ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (2),
    .TIMEOUT    (TO)
  ) dut (
    .Clk         (clk),
    .Reset_N     (rst_n),
    .hz          (hz_if),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic in_t mk(int rs, int rt, int urs, int urt, int jmp, int mr, int rd,
                             int br, int ir, int ma, int dr);
    in_t v;
    v.id_rs           = 2'(rs);
    v.id_rt           = 2'(rt);
    v.id_use_rs       = 1'(urs);
    v.id_use_rt       = 1'(urt);
    v.id_jump         = 1'(jmp);
    v.ex_mem_read     = 1'(mr);
    v.ex_rd           = 2'(rd);
    v.ex_branch_taken = 1'(br);
    v.imem_ready      = 1'(ir);
    v.mem_access      = 1'(ma);
    v.dmem_ready      = 1'(dr);
    return v;
  endfunction

  function automatic logic [6:0] get_ctrl();
    return {hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_write, hz_if.ex_mem_write,
            hz_if.mem_wb_write, hz_if.if_id_flush, hz_if.id_ex_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int classify(in_t v);
    bit rs_hit, rt_hit;
    rs_hit = v.id_use_rs && (v.id_rs == v.ex_rd);
    rt_hit = v.id_use_rt && (v.id_rt == v.ex_rd);
    if (v.mem_access && !v.dmem_ready) return 0;
    if (v.ex_branch_taken)             return 1;
    if (v.ex_mem_read && (rs_hit || rt_hit)) return 2;
    if (v.id_jump)                     return 3;
    if (!v.imem_ready)                 return 4;
    return 5;
  endfunction

  function automatic logic [6:0] model_ctrl(in_t v);
    if (!m_live) return 7'b0;
    return RULE_OUT[classify(v)];
  endfunction

  task automatic model_reset();
    m_stall = 0; m_flush = 0; m_wait = 0; m_kind = 0;
    m_timeout = 0; m_live = 0;
  endtask

  task automatic model_tick(input in_t v);
    int r, nk;
    logic [6:0] o;
    r = classify(v);
    o = RULE_OUT[r];
    if (!o[6]) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
    if (r == 1 || r == 3) m_flush = (m_flush >= 65535) ? 65535 : m_flush + 1;
    nk = (r == 0) ? 1 : (r == 4) ? 2 : 0;
    if (nk == 0) begin
      m_wait = 0;
    end else if (m_kind != 0) begin
      m_wait++;
      if (m_wait >= TO) m_timeout = 1;
    end
    m_kind = nk;
  endtask

  task automatic check_regs(input string tag);
    state_t es;
    es = (m_kind == 1) ? ST_DWAIT : (m_kind == 2) ? ST_IWAIT : ST_RUN;
    chk({tag, "_stall_cnt"}, 32'(hz_if.stall_cnt), m_stall);
    chk({tag, "_flush_cnt"}, 32'(hz_if.flush_cnt), m_flush);
    chk({tag, "_timeout"}, 32'(hz_if.mem_timeout), 32'(m_timeout));
    chk({tag, "_state"}, 32'(dbg_state), 32'(es));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input in_t v);
    hz_if.id_rs           = v.id_rs;
    hz_if.id_rt           = v.id_rt;
    hz_if.id_use_rs       = v.id_use_rs;
    hz_if.id_use_rt       = v.id_use_rt;
    hz_if.id_jump         = v.id_jump;
    hz_if.ex_mem_read     = v.ex_mem_read;
    hz_if.ex_rd           = v.ex_rd;
    hz_if.ex_branch_taken = v.ex_branch_taken;
    hz_if.imem_ready      = v.imem_ready;
    hz_if.mem_access      = v.mem_access;
    hz_if.dmem_ready      = v.dmem_ready;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input in_t v, input logic [6:0] exp_ctrl, input string tag);
    logic [6:0] e;
    drive(v);
    exp_q.push_back(exp_ctrl);
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, "_ctrl"}, 32'(get_ctrl()), 32'(e));
    model_tick(v);
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset_ctrl", 32'(get_ctrl()), 32'h0);
    chk("reset_stall", 32'(hz_if.stall_cnt), 32'h0);
    chk("reset_flush", 32'(hz_if.flush_cnt), 32'h0);
    chk("reset_timeout", 32'(hz_if.mem_timeout), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(ST_RUN));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_live = 1;
  endtask

  // ---------------- test ----------------
  vec_t tbl[14];
  in_t  v_idle, v_lu, v_iw, v_dw;

  initial begin
    n_checks = 0;
    n_errors = 0;
    v_idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    v_lu   = mk(2, 0, 1, 0, 0, 1, 2, 0, 1, 0, 1);
    v_iw   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    v_dw   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 7'b1111100};
    tbl[1]  = '{mk(2, 0, 1, 0, 0, 1, 2, 0, 1, 0, 1), 7'b0011101};
    tbl[2]  = '{mk(0, 3, 0, 1, 0, 1, 3, 0, 1, 0, 1), 7'b0011101};
    tbl[3]  = '{mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1), 7'b1111100};
    tbl[4]  = '{mk(1, 1, 1, 1, 0, 0, 1, 0, 1, 0, 1), 7'b1111100};
    tbl[5]  = '{mk(2, 3, 1, 1, 0, 1, 1, 0, 1, 0, 1), 7'b1111100};
    tbl[6]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1), 7'b1111110};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1), 7'b1111111};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 7'b0111110};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 7'b0000000};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 7'b1111100};
    tbl[11] = '{mk(2, 0, 1, 0, 1, 1, 2, 1, 0, 1, 0), 7'b0000000};
    tbl[12] = '{mk(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 1), 7'b0011101};
    tbl[13] = '{mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1), 7'b1111111};

    rst_n = 1'b0;
    drive(v_idle);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].in, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Load-use: one bubble, then the load has moved on to MEM.
    do_reset();
    step(v_lu, 7'b0011101, "lu");
    chk("lu_stall_cnt", 32'(hz_if.stall_cnt), 32'd1);
    step(v_idle, 7'b1111100, "lu_after");

    // Branch beats a simultaneous load-use.
    do_reset();
    step(mk(2, 0, 1, 0, 0, 1, 2, 1, 1, 0, 1), 7'b1111111, "br_lu");
    chk("br_lu_flush_cnt", 32'(hz_if.flush_cnt), 32'd1);
    chk("br_lu_stall_cnt", 32'(hz_if.stall_cnt), 32'd0);

    // Data wait held for three cycles with a taken branch frozen in EX.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), 7'b0000000, "dw_br");
      chk("dw_br_state", 32'(dbg_state), 32'(ST_DWAIT));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1), 7'b1111111, "dw_br_rel");
    chk("dw_br_stall_cnt", 32'(hz_if.stall_cnt), 32'd3);
    chk("dw_br_flush_cnt", 32'(hz_if.flush_cnt), 32'd1);

    // Watchdog: fetch wait held six cycles; timeout after the 4th cycle in IWAIT.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(v_iw, 7'b0111110, "wd");
      chk($sformatf("wd_timeout_c%0d", k), 32'(hz_if.mem_timeout), 32'(k >= 5));
    end
    step(v_idle, 7'b1111100, "wd_rel");
    step(v_idle, 7'b1111100, "wd_idle");
    chk("wd_timeout_sticky", 32'(hz_if.mem_timeout), 32'd1);

    // Reset dropped mid-DWAIT, between clock edges.
    do_reset();
    for (int i = 0; i < 6; i++) step(v_dw, 7'b0000000, "rdw");
    drive(v_idle);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rdw_ctrl", 32'(get_ctrl()), 32'h0);
    chk("rdw_state", 32'(dbg_state), 32'(ST_RUN));
    chk("rdw_stall", 32'(hz_if.stall_cnt), 32'h0);
    chk("rdw_timeout", 32'(hz_if.mem_timeout), 32'h0);
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      in_t v;
      v.id_rs           = 2'($urandom_range(0, 3));
      v.id_rt           = 2'($urandom_range(0, 3));
      v.id_use_rs       = 1'($urandom_range(0, 1));
      v.id_use_rt       = 1'($urandom_range(0, 1));
      v.id_jump         = ($urandom_range(0, 5) == 0);
      v.ex_mem_read     = 1'($urandom_range(0, 1));
      v.ex_rd           = 2'($urandom_range(0, 3));
      v.ex_branch_taken = ($urandom_range(0, 5) == 0);
      v.imem_ready      = ($urandom_range(0, 3) != 0);
      v.mem_access      = ($urandom_range(0, 3) == 0);
      v.dmem_ready      = ($urandom_range(0, 2) != 0);
      step(v, model_ctrl(v), "rand");
    end

    // Saturation: hold a load-use for 65540 cycles.
    do_reset();
    drive(v_lu);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_stall_cnt", 32'(hz_if.stall_cnt), 32'hFFFF);
    chk("sat_flush_cnt", 32'(hz_if.flush_cnt), 32'h0);
    @(posedge clk);
    #1;
    chk("sat_stall_hold", 32'(hz_if.stall_cnt), 32'hFFFF);
    chk("sat_ctrl", 32'(get_ctrl()), 32'(7'b0011101));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
